// File: rtl/dbg_uart_bridge.sv
// dbg_uart_bridge
//   Byte-oriented debug monitor sitting between a UART byte interface and the
//   b16 system bus. The host sets an address pointer, reads/writes 16-bit
//   words or single bytes, and reads an 8-bit status byte. While bus_req is
//   high the top-level mux hands addr/rd/wr/wdata to this block and stalls
//   the CPU.
//
//   Optional build macro: DBG_UART_ACK_EN -- when defined, SETADDR, WRITE and
//   WRBYTE each answer with one ack byte (0x06) through the TX state.
//
// Handshake: rx_valid and tx_valid are single-cycle strobes with no back
//   pressure. rx_data is taken in the cycle rx_valid is high; tx_data is
//   valid only in the cycle tx_valid is high. Successive tx strobes are
//   spaced TX_GAP clocks apart (one UART frame time).
//
// Ports:
//   clk, nreset      clock (rising edge), async active-low reset
//   rx_valid/rx_data received byte strobe and data
//   tx_valid/tx_data byte-to-send strobe and data
//   bus_req          debugger owns the bus
//   addr, rd, wr     byte address, read strobe, byte-lane write strobes
//   wdata, rdata     bus write / read data
//   status           byte returned by the STATUS command
module dbg_uart_bridge #(
  parameter int TX_GAP     = 5000,
  parameter int RX_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        bus_req,
  output logic [15:0] addr,
  output logic        rd,
  output logic [1:0]  wr,
  input  logic [15:0] rdata,
  output logic [15:0] wdata,
  input  logic [7:0]  status
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARG1   = 3'd1;
  localparam logic [2:0] S_ARG2   = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_TX     = 3'd4;

  localparam logic [7:0] OP_SETADDR = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] OP_WRITE   = 8'h03;
  localparam logic [7:0] OP_WRBYTE  = 8'h04;
  localparam logic [7:0] OP_STATUS  = 8'h05;
  localparam logic [7:0] ACK_BYTE   = 8'h06;

`ifdef DBG_UART_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  // Counters only ever hold 0..N-1, so clog2(N) bits suffice.
  localparam int GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam int TO_W  = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(TX_GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(RX_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       hi_q, hi_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic [1:0]       wr_q, wr_d;
  logic             bus_req_q, bus_req_d;
  logic             acc_last_q, acc_last_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       tx_lo_q, tx_lo_d;
  logic             tx_more_q, tx_more_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TO_W-1:0]  to_q, to_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hi_d       = hi_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    bus_req_d  = bus_req_q;
    acc_last_d = acc_last_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_lo_d    = tx_lo_q;
    tx_more_d  = tx_more_q;
    gap_d      = gap_q;
    to_d       = to_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_SETADDR, OP_WRITE, OP_WRBYTE: begin
              op_d    = rx_data;
              to_d    = '0;
              state_d = S_ARG1;
            end
            OP_READ: begin
              op_d       = rx_data;
              bus_req_d  = 1'b1;
              rd_d       = 1'b1;
              acc_last_d = 1'b0;
              state_d    = S_ACCESS;
            end
            OP_STATUS: begin
              op_d       = rx_data;
              tx_valid_d = 1'b1;
              tx_data_d  = status;
              tx_more_d  = 1'b0;
              gap_d      = GAP_RELOAD;
              state_d    = S_TX;
            end
            default: ; // unknown opcode: stay in IDLE
          endcase
        end
      end

      S_ARG1, S_ARG2: begin
        if (rx_valid) begin
          to_d = '0;
          if (state_q == S_ARG1 && op_q == OP_WRBYTE) begin
            // Single-byte write: replicate onto both lanes, strobe the one
            // the pointer's low bit selects.
            wdata_d    = {rx_data, rx_data};
            wr_d       = addr_q[0] ? 2'b10 : 2'b01;
            bus_req_d  = 1'b1;
            acc_last_d = 1'b0;
            state_d    = S_ACCESS;
          end else if (state_q == S_ARG1) begin
            hi_d    = rx_data;
            state_d = S_ARG2;
          end else if (op_q == OP_SETADDR) begin
            addr_d = {hi_q, rx_data};
            if (ACK_EN) begin
              tx_valid_d = 1'b1;
              tx_data_d  = ACK_BYTE;
              tx_more_d  = 1'b0;
              gap_d      = GAP_RELOAD;
              state_d    = S_TX;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            wdata_d    = {hi_q, rx_data};
            wr_d       = 2'b11;
            bus_req_d  = 1'b1;
            acc_last_d = 1'b0;
            state_d    = S_ACCESS;
          end
        end else if (to_q == TO_LAST) begin
          // Host went quiet mid-command: drop the partial argument.
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      S_ACCESS: begin
        if (!acc_last_q) begin
          acc_last_d = 1'b1;
        end else begin
          // End of the 2nd bus clock: rdata is sampled here and the pointer
          // advances in the same edge that releases the bus.
          bus_req_d = 1'b0;
          rd_d      = 1'b0;
          wr_d      = 2'b00;
          addr_d    = (op_q == OP_WRBYTE) ? addr_q + 16'd1 : addr_q + 16'd2;
          if (op_q == OP_READ) begin
            tx_valid_d = 1'b1;
            tx_data_d  = rdata[15:8];
            tx_lo_d    = rdata[7:0];
            tx_more_d  = 1'b1;
            gap_d      = GAP_RELOAD;
            state_d    = S_TX;
          end else if (ACK_EN) begin
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_BYTE;
            tx_more_d  = 1'b0;
            gap_d      = GAP_RELOAD;
            state_d    = S_TX;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_TX: begin
        // gap_q counts down from TX_GAP-1 starting in the pulse cycle, so the
        // next pulse (or the return to IDLE) lands exactly TX_GAP clocks later.
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (tx_more_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = tx_lo_q;
          tx_more_d  = 1'b0;
          gap_d      = GAP_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 2'b00;
      bus_req_q  <= 1'b0;
      acc_last_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_lo_q    <= '0;
      tx_more_q  <= 1'b0;
      gap_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      bus_req_q  <= bus_req_d;
      acc_last_q <= acc_last_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_lo_q    <= tx_lo_d;
      tx_more_q  <= tx_more_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign bus_req  = bus_req_q;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign wdata    = wdata_q;
  // Word reads go out aligned; the pointer itself keeps its low bit.
  assign addr     = (state_q == S_ACCESS && op_q == OP_READ) ? {addr_q[15:1], 1'b0} : addr_q;

endmodule

// File: tb/tb_dbg_uart_bridge.sv
`timescale 1ns/1ps
module tb_dbg_uart_bridge;
  localparam int G = 7;   // TX_GAP
  localparam int R = 40;  // RX_TIMEOUT
`ifdef DBG_UART_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic [15:0] addr;
  logic        rd;
  logic [1:0]  wr;
  logic [15:0] rdata = 16'h0000;
  logic [15:0] wdata;
  logic [7:0]  status = 8'h00;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dbg_uart_bridge #(.TX_GAP(G), .RX_TIMEOUT(R)) dut (
    .clk(clk), .nreset(nreset), .rx_valid(rx_valid), .tx_valid(tx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .bus_req(bus_req), .addr(addr),
    .rd(rd), .wr(wr), .rdata(rdata), .wdata(wdata), .status(status)
  );

  // ---------------- scoreboard ----------------
  // tx entry: {cycle[31:0], byte[7:0]}
  logic [39:0] tx_exp_q[$];
  // bus entry: {cycle[31:0], rd, wr[1:0], addr[15:0], wdata[15:0]}
  logic [66:0] bus_exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] m_wdata = 16'h0000;
  logic [15:0] mem_word = 16'h0000;
  int busy = 0;  // first cycle in which the bridge accepts a new opcode

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents byte b in the first cycle >= c; t returns the cycle it was taken.
  task automatic send_at(input logic [7:0] b, input int c, output int t);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic push_tx(input int c, input logic [7:0] b);
    tx_exp_q.push_back({32'(c), b});
  endtask

  task automatic push_bus(input int c, input logic r, input logic [1:0] w,
                          input logic [15:0] a, input logic [15:0] d);
    bus_exp_q.push_back({32'(c), r, w, a, d});
  endtask

  // c: first cycle after the command's own work is done
  task automatic finish_cmd(input int c);
    if (ACK) begin
      push_tx(c, 8'h06);
      busy = c + G;
    end else begin
      busy = c;
    end
  endtask

  task automatic cmd_setaddr(input logic [15:0] v);
    int t;
    send_at(8'h01, busy, t);
    send_at(v[15:8], 0, t);
    send_at(v[7:0], 0, t);
    m_addr = v;
    finish_cmd(t + 1);
  endtask

  task automatic cmd_write(input logic [15:0] v);
    int t;
    send_at(8'h03, busy, t);
    send_at(v[15:8], 0, t);
    send_at(v[7:0], 0, t);
    push_bus(t + 1, 1'b0, 2'b11, m_addr, v);
    m_wdata = v;
    m_addr  = m_addr + 16'd2;
    finish_cmd(t + 3);
  endtask

  task automatic cmd_wrbyte(input logic [7:0] b);
    int t;
    send_at(8'h04, busy, t);
    send_at(b, 0, t);
    push_bus(t + 1, 1'b0, m_addr[0] ? 2'b10 : 2'b01, m_addr, {b, b});
    m_wdata = {b, b};
    m_addr  = m_addr + 16'd1;
    finish_cmd(t + 3);
  endtask

  task automatic cmd_read(input logic [15:0] w);
    int t;
    mem_word = w;
    send_at(8'h02, busy, t);
    push_bus(t + 1, 1'b1, 2'b00, {m_addr[15:1], 1'b0}, m_wdata);
    push_tx(t + 3, w[15:8]);
    push_tx(t + 3 + G, w[7:0]);
    m_addr = m_addr + 16'd2;
    busy = t + 3 + 2 * G;
  endtask

  task automatic cmd_status(input logic [7:0] s, input int c);
    int t;
    status = s;
    send_at(8'h05, (c > busy) ? c : busy, t);
    status = 8'($urandom);
    push_tx(t + 1, s);
    busy = t + 1 + G;
  endtask

  task automatic cmd_unknown();
    int t;
    logic [7:0] b;
    b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(7, 255));
    send_at(b, busy, t);
    busy = t + 1;
  endtask

  // Random bytes while the bridge is in ACCESS/TX; they must be discarded.
  task automatic junk(input int n);
    int t;
    for (int i = 0; i < n; i++)
      if (cyc + 2 < busy) send_at(8'($urandom), 0, t);
  endtask

  task automatic check_idle();
    @(negedge clk);
    while (cyc < busy) @(negedge clk);
    check("addr_ptr", addr, m_addr);
    check("wdata_reg", wdata, m_wdata);
    check("bus_req_idle", bus_req, 0);
  endtask

  // ---------------- read-data responder ----------------
  // Only the 2nd read clock carries the real word, so an early capture shows.
  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      if (rd) begin
        n++;
        rdata = (n >= 2) ? mem_word : ~mem_word;
      end else begin
        n = 0;
        rdata = 16'($urandom);
      end
    end
  end

  // ---------------- tx monitor ----------------
  initial begin
    int last = -1;
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (nreset && tx_valid) begin
        if (last >= 0) check("tx_gap_ge_txgap", 64'(cyc - last >= G), 1);
        last = cyc;
        if (tx_exp_q.size() == 0) begin
          check("tx_unexpected", tx_valid, 0);
        end else begin
          e = tx_exp_q.pop_front();
          check("tx_cycle", cyc, e[39:8]);
          check("tx_data", tx_data, e[7:0]);
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    int ph = 0;
    logic [66:0] e;
    logic [34:0] cur;
    forever begin
      @(negedge clk);
      check("rd_wr_exclusive", rd & (|wr), 0);
      if (!nreset) begin
        ph = 0;
      end else begin
        case (ph)
          0: begin
            if (bus_req) begin
              if (bus_exp_q.size() == 0) begin
                check("bus_unexpected", bus_req, 0);
                cur = {rd, wr, addr, wdata};
              end else begin
                e = bus_exp_q.pop_front();
                check("bus_cycle", cyc, e[66:35]);
                check("bus_rd", rd, e[34]);
                check("bus_wr", wr, e[33:32]);
                check("bus_addr", addr, e[31:16]);
                check("bus_wdata", wdata, e[15:0]);
                cur = e[34:0];
              end
              ph = 1;
            end else begin
              check("strobes_idle", {rd, wr}, 0);
            end
          end
          1: begin
            check("bus_hold_2nd_clk", {bus_req, rd, wr, addr, wdata}, {1'b1, cur});
            ph = 2;
          end
          default: begin
            check("bus_release", {bus_req, rd, wr}, 0);
            ph = 0;
          end
        endcase
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int op;
    #1 nreset = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_addr", addr, 0);
    check("rst_rd_wr", {rd, wr}, 0);
    check("rst_wdata", wdata, 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    busy = cyc + 1;

    // status reply, no bus activity
    cmd_status(8'h29, 0);
    check_idle();

    // word write
    cmd_setaddr(16'h1234);
    cmd_write(16'hBEEF);
    check_idle();

    // word read with bytes thrown at it during the access and reply
    cmd_setaddr(16'h1234);
    cmd_read(16'hCAFE);
    junk(3);
    check_idle();

    // byte writes on both lanes, wrap-around of the pointer
    cmd_setaddr(16'h0005);
    cmd_wrbyte(8'h7E);
    check_idle();
    cmd_wrbyte(8'h3C);
    cmd_setaddr(16'hFFFE);
    cmd_read(16'h1357);
    check_idle();
    cmd_setaddr(16'hFFFF);
    cmd_wrbyte(8'hA1);
    check_idle();

    // ARG2 timeout: the next opcode arrives the first cycle after the abort
    send_at(8'h01, busy, t);
    send_at(8'h12, 0, t);
    cmd_status(8'h5C, t + R + 1);
    check_idle();

    // ARG1 timeout on WRITE: no bus cycle
    send_at(8'h03, busy, t);
    cmd_status(8'hC3, t + R + 1);
    check_idle();

    // argument in the last cycle before the timeout is still accepted
    send_at(8'h01, busy, t);
    send_at(8'hA5, 0, t);
    send_at(8'h5A, t + R, t);
    m_addr = 16'hA55A;
    finish_cmd(t + 1);
    check_idle();

    // unknown opcodes are ignored
    for (int i = 0; i < 4; i++) cmd_unknown();
    cmd_status(8'h81, 0);
    check_idle();

    // randomized command mix
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: cmd_setaddr(($urandom_range(0, 2) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3))
                                                    : 16'($urandom));
        1: cmd_write(16'($urandom));
        2: cmd_wrbyte(8'($urandom));
        3: cmd_read(16'($urandom));
        4: cmd_status(8'($urandom), 0);
        default: cmd_unknown();
      endcase
      junk($urandom_range(0, 2));
      check_idle();
    end

    // async reset in the first ACCESS clock of a READ: no completion, no reply
    @(negedge clk);
    while (cyc < busy) @(negedge clk);
    mem_word = 16'h9999;
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("pre_rst_bus_req", bus_req, 1);
    #1 nreset = 1'b0;
    #1;
    check("async_rst_bus_req", bus_req, 0);
    check("async_rst_rd", rd, 0);
    check("async_rst_addr", addr, 0);
    check("async_rst_wdata", wdata, 0);
    check("async_rst_tx_valid", tx_valid, 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    m_addr  = 16'h0000;
    m_wdata = 16'h0000;
    busy = cyc + 3 * G + 4;
    check_idle();
    cmd_status(8'h42, 0);
    check_idle();

    repeat (G + 5) @(negedge clk);
    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("bus_queue_drained", bus_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
